// File: rtl/regfile_write_select_if.sv
// Write-select bus: writeback request/sweep control in, registered
// one-hot register select and sweep status out.
interface regfile_write_select_if #(
    parameter int unsigned ADDR_W = 5
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeRegister;
    logic              sweep_start;
    logic [DEPTH-1:0]  sel;
    logic              sel_valid;
    logic              sweep_busy;
    logic              sweep_done;
    logic              write_dropped;

    modport master (
        output ctrl_writeEnable,
        output ctrl_writeRegister,
        output sweep_start,
        input  sel,
        input  sel_valid,
        input  sweep_busy,
        input  sweep_done,
        input  write_dropped
    );

    modport slave (
        input  ctrl_writeEnable,
        input  ctrl_writeRegister,
        input  sweep_start,
        output sel,
        output sel_valid,
        output sweep_busy,
        output sweep_done,
        output write_dropped
    );
endinterface

// File: rtl/regfile_write_select.sv
// Registered write-select decoder: binary write address to one-hot register select,
// with optional register-0 masking and a sequential sweep over all writable registers.
module regfile_write_select #(
    parameter int unsigned ADDR_W    = 5,
    parameter bit          MASK_ZERO = 1'b1
) (
    input logic                   clock,
    input logic                   ctrl_reset_n,
    regfile_write_select_if.slave bus
);
    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST = MASK_ZERO ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSweep
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] count_q;

    logic             write_hit;
    logic [DEPTH-1:0] write_sel;
    logic [DEPTH-1:0] sweep_sel;

    // Enable gates the address first, so an undriven address with no write stays harmless.
    always_comb begin
        write_hit = 1'b0;
        write_sel = '0;
        sweep_sel = '0;
        if (bus.ctrl_writeEnable) begin
            write_hit = !(MASK_ZERO && (bus.ctrl_writeRegister == '0));
        end
        if (write_hit) begin
            write_sel[bus.ctrl_writeRegister] = 1'b1;
        end
        sweep_sel[count_q] = 1'b1;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q           <= StIdle;
            count_q           <= '0;
            bus.sel           <= '0;
            bus.sel_valid     <= 1'b0;
            bus.sweep_busy    <= 1'b0;
            bus.sweep_done    <= 1'b0;
            bus.write_dropped <= 1'b0;
        end else begin
            bus.sweep_done    <= 1'b0;
            bus.write_dropped <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A write sampled alongside sweep_start is still honoured.
                    bus.sel       <= write_sel;
                    bus.sel_valid <= write_hit;
                    if (bus.sweep_start) begin
                        state_q        <= StSweep;
                        count_q        <= FIRST;
                        bus.sweep_busy <= 1'b1;
                    end
                end
                StSweep: begin
                    bus.sel           <= sweep_sel;
                    bus.sel_valid     <= 1'b1;
                    bus.write_dropped <= bus.ctrl_writeEnable;
                    if (count_q == LAST) begin
                        state_q        <= StIdle;
                        count_q        <= '0;
                        bus.sweep_busy <= 1'b0;
                        bus.sweep_done <= 1'b1;
                    end else begin
                        count_q <= count_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    sel_onehot0_a : assert property (@(posedge clock) disable iff (!ctrl_reset_n)
        $onehot0(bus.sel));
    sel_valid_a : assert property (@(posedge clock) disable iff (!ctrl_reset_n)
        bus.sel_valid == (|bus.sel));
    zero_masked_a : assert property (@(posedge clock) disable iff (!ctrl_reset_n)
        !(MASK_ZERO && bus.sel[0]));
endmodule
